run_step_controller: RTL and testbench
======================================

// Module: run_step_controller
// PURPOSE
//  Parametrised successor to the step-clock mux between debug_unit and data_path. Runs on one clock, never gates a clock.
//  Drives a clock-enable o_dp_enable for the data path. Modes: free-run, single step, N-step burst.
//  Stops on N PC breakpoints, on the data-path halt, or on a user STOP, and reports the stop cause to debug_unit.
// PARAMETERS
//  NB_PC        32  width of PC value and breakpoint addresses
//  N_BP         4   number of breakpoint registers (1..16)
//  NB_BP_IDX    2   clog2(N_BP), width of breakpoint index
//  NB_STEP      16  width of burst step count and step counter
// PORTS
//  i_clock         in   1          system clock (clk_wiz domain)
//  i_reset         in   1          asynchronous, active-low reset
//  i_cmd_valid     in   1          command strobe, one cycle per command
//  i_cmd           in   3          CMD_RUN/STEP/BURST/STOP/BP_SET/BP_CLR
//  i_step_count    in   NB_STEP    burst length, sampled with CMD_BURST
//  i_bp_index      in   NB_BP_IDX  breakpoint slot for BP_SET/BP_CLR
//  i_bp_addr       in   NB_PC      breakpoint PC, sampled with BP_SET
//  i_pc_value      in   NB_PC      current data-path PC
//  i_hlt           in   1          data-path halt instruction retired
//  o_dp_enable     out  1          data-path advance enable (comb. from state+inputs)
//  o_cmd_err       out  1          one-cycle pulse: command rejected
//  o_stop_pulse    out  1          one-cycle pulse on entry to IDLE/HALTED from a running state
//  o_stop_cause    out  3          NONE/STEP_DONE/BREAKPOINT/HALT/USER_STOP
//  o_bp_hit_index  out  NB_BP_IDX  slot that caused last BREAKPOINT stop
//  o_steps_done    out  NB_STEP    enabled cycles since last RUN/STEP/BURST
//  o_state         out  3          IDLE/RUN/BURST/HALTED
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; all bp slots disabled, addr 0; counters 0.
//  States:
//   IDLE:   RUN->RUN; STEP->BURST with remaining=1; BURST n>0->BURST with remaining=n.
//   IDLE:   BURST n==0-> stays IDLE, stop_pulse, cause STEP_DONE, no enable.
//   RUN:    o_dp_enable=1 unless stop condition this cycle.
//   BURST:  o_dp_enable=1, remaining decrements per enabled cycle.
//   BURST:  remaining reaching 0 -> IDLE, cause STEP_DONE.
//   HALTED: entered on i_hlt. Accepts STOP (->IDLE, cause kept) and BP_SET/BP_CLR only.
//  Stop conditions, evaluated combinationally in RUN/BURST; enable forced 0 that same cycle.
//   Priority: i_hlt > user STOP > bp match > count expiry.
//  Breakpoint match: enabled slot with addr==i_pc_value; lowest index wins.
//   Match ignored on first enabled cycle after RUN/STEP/BURST acceptance, so execution can leave a bp PC.
//  Commands: accepted the cycle i_cmd_valid=1.
//   RUN/STEP/BURST while RUN/BURST/HALTED -> dropped, o_cmd_err pulse next cycle.
//   Undefined codes -> o_cmd_err pulse.
//   STOP in IDLE -> no effect, no error.
//   BP_SET/BP_CLR legal in any state; effective the cycle after acceptance.
//   BP_SET on an enabled slot overwrites it.
//  o_steps_done: cleared on RUN/STEP/BURST acceptance, +1 per o_dp_enable cycle, saturates at all-ones.
//  o_stop_cause/o_bp_hit_index: registered at the stop, held until the next RUN/STEP/BURST acceptance (then cleared to NONE).
//  Reset mid-run: immediate async return to reset values; breakpoints lost.
// STRUCTURE
//  Package run_ctrl_pkg: CMD_* (3b), ST_* (3b), CAUSE_* (3b) localparams.
//  Sub-module bp_matcher: N_BP addr/valid regs, comparators, lowest-index priority encoder -> hit, hit_index.
//  Top: FSM, burst down-counter, step counter, command decode.
// TESTING
//  1 Reset then STEP with pc=0 -> exactly one o_dp_enable cycle; stop_pulse; cause STEP_DONE; steps_done=1.
//  2 BURST count=5 -> 5 enable cycles; state IDLE; steps_done=5.
//    BURST count=0 -> 0 enables, stop_pulse, STEP_DONE.
//  3 BP_SET slot2=0x10, RUN, pc +4/enable from 0 -> enable low at pc=0x10; cause BREAKPOINT; hit_index=2; steps_done=4.
//    Re-RUN -> leaves 0x10.
//  4 RUN, assert i_hlt with bp matching same cycle -> cause HALT; state HALTED.
//    RUN in HALTED -> o_cmd_err; STOP -> IDLE.
//  5 BURST 100; at cycle 10 send RUN -> o_cmd_err.
//    STOP at cycle 20 -> cause USER_STOP; steps_done=20.
//  6 RUN with slots 0 and 3 both =0x8 -> hit_index 0.
//    Drop i_reset mid-RUN -> all outputs 0 and bp slots cleared asynchronously.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - command, state and stop-cause encodings for the run/step controller
package run_ctrl_pkg;

    localparam logic [2:0] CMD_RUN    = 3'd0;
    localparam logic [2:0] CMD_STEP   = 3'd1;
    localparam logic [2:0] CMD_BURST  = 3'd2;
    localparam logic [2:0] CMD_STOP   = 3'd3;
    localparam logic [2:0] CMD_BP_SET = 3'd4;
    localparam logic [2:0] CMD_BP_CLR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_BURST  = 3'd2,
        ST_HALTED = 3'd3
    } run_state_e;

    localparam logic [2:0] CAUSE_NONE       = 3'd0;
    localparam logic [2:0] CAUSE_STEP_DONE  = 3'd1;
    localparam logic [2:0] CAUSE_BREAKPOINT = 3'd2;
    localparam logic [2:0] CAUSE_HALT       = 3'd3;
    localparam logic [2:0] CAUSE_USER_STOP  = 3'd4;

    function automatic logic is_start_cmd(input logic [2:0] cmd);
        return (cmd == CMD_RUN) || (cmd == CMD_STEP) || (cmd == CMD_BURST);
    endfunction

endpackage

// File: rtl/bp_matcher.sv
// rtl/bp_matcher.sv - breakpoint slot registers with lowest-index match priority
module bp_matcher
    import run_ctrl_pkg::*;
#(
    parameter int NB_PC     = 32,
    parameter int N_BP      = 4,
    parameter int NB_BP_IDX = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_set,
    input  logic                 i_clr,
    input  logic [NB_BP_IDX-1:0] i_index,
    input  logic [NB_PC-1:0]     i_addr,
    input  logic [NB_PC-1:0]     i_pc,
    output logic                 o_hit,
    output logic [NB_BP_IDX-1:0] o_hit_index
);

    logic [NB_PC-1:0] addr_q [N_BP];
    logic [N_BP-1:0]  valid_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= '0;
            for (int i = 0; i < N_BP; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BP; i++) begin
                if (int'(i_index) == i) begin
                    if (i_set) begin
                        valid_q[i] <= 1'b1;
                        addr_q[i]  <= i_addr;
                    end else if (i_clr) begin
                        valid_q[i] <= 1'b0;
                        addr_q[i]  <= '0;
                    end
                end
            end
        end
    end

    // Scan from the top down so the lowest matching slot is the last one written.
    always_comb begin
        o_hit       = 1'b0;
        o_hit_index = '0;
        for (int i = N_BP - 1; i >= 0; i--) begin
            if (valid_q[i] && (addr_q[i] == i_pc)) begin
                o_hit       = 1'b1;
                o_hit_index = NB_BP_IDX'(i);
            end
        end
    end

endmodule

// File: rtl/run_step_controller.sv
// rtl/run_step_controller.sv - data-path clock-enable controller: free run, single step, N-step burst
module run_step_controller
    import run_ctrl_pkg::*;
#(
    parameter int NB_PC     = 32,
    parameter int N_BP      = 4,
    parameter int NB_BP_IDX = 2,
    parameter int NB_STEP   = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [2:0]           i_cmd,
    input  logic [NB_STEP-1:0]   i_step_count,
    input  logic [NB_BP_IDX-1:0] i_bp_index,
    input  logic [NB_PC-1:0]     i_bp_addr,
    input  logic [NB_PC-1:0]     i_pc_value,
    input  logic                 i_hlt,
    output logic                 o_dp_enable,
    output logic                 o_cmd_err,
    output logic                 o_stop_pulse,
    output logic [2:0]           o_stop_cause,
    output logic [NB_BP_IDX-1:0] o_bp_hit_index,
    output logic [NB_STEP-1:0]   o_steps_done,
    output logic [2:0]           o_state
);

    run_state_e           state_q, state_d;
    logic [NB_STEP-1:0]   remain_q, remain_d;
    logic [NB_STEP-1:0]   steps_q, steps_d;
    logic [2:0]           cause_q, cause_d;
    logic [NB_BP_IDX-1:0] hit_idx_q, hit_idx_d;
    logic                 first_q, first_d;
    logic                 stop_pulse_q, stop_pulse_d;
    logic                 cmd_err_q, cmd_err_d;

    logic                 bp_hit;
    logic [NB_BP_IDX-1:0] bp_hit_index;
    logic                 cmd_start, cmd_stop, cmd_bad;

    assign cmd_start = i_cmd_valid && is_start_cmd(i_cmd);
    assign cmd_stop  = i_cmd_valid && (i_cmd == CMD_STOP);
    assign cmd_bad   = i_cmd_valid && (i_cmd > CMD_BP_CLR);

    bp_matcher #(
        .NB_PC     (NB_PC),
        .N_BP      (N_BP),
        .NB_BP_IDX (NB_BP_IDX)
    ) u_bp_matcher (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_set       (i_cmd_valid && (i_cmd == CMD_BP_SET)),
        .i_clr       (i_cmd_valid && (i_cmd == CMD_BP_CLR)),
        .i_index     (i_bp_index),
        .i_addr      (i_bp_addr),
        .i_pc        (i_pc_value),
        .o_hit       (bp_hit),
        .o_hit_index (bp_hit_index)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            steps_q      <= '0;
            cause_q      <= CAUSE_NONE;
            hit_idx_q    <= '0;
            first_q      <= 1'b0;
            stop_pulse_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            steps_q      <= steps_d;
            cause_q      <= cause_d;
            hit_idx_q    <= hit_idx_d;
            first_q      <= first_d;
            stop_pulse_q <= stop_pulse_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        steps_d      = steps_q;
        cause_d      = cause_q;
        hit_idx_d    = hit_idx_q;
        first_d      = first_q;
        stop_pulse_d = 1'b0;
        cmd_err_d    = cmd_bad;
        o_dp_enable  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    steps_d   = '0;
                    cause_d   = CAUSE_NONE;
                    hit_idx_d = '0;
                    first_d   = 1'b1;
                    if (i_cmd == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else if (i_cmd == CMD_STEP) begin
                        state_d  = ST_BURST;
                        remain_d = NB_STEP'(1);
                    end else if (i_step_count == '0) begin
                        // Zero-length burst completes on the spot without advancing the data path.
                        stop_pulse_d = 1'b1;
                        cause_d      = CAUSE_STEP_DONE;
                        first_d      = 1'b0;
                    end else begin
                        state_d  = ST_BURST;
                        remain_d = i_step_count;
                    end
                end
            end
            ST_RUN, ST_BURST: begin
                if (cmd_start) begin
                    cmd_err_d = 1'b1;
                end
                first_d = 1'b0;
                if (i_hlt) begin
                    state_d      = ST_HALTED;
                    cause_d      = CAUSE_HALT;
                    stop_pulse_d = 1'b1;
                end else if (cmd_stop) begin
                    state_d      = ST_IDLE;
                    cause_d      = CAUSE_USER_STOP;
                    stop_pulse_d = 1'b1;
                end else if (bp_hit && !first_q) begin
                    state_d      = ST_IDLE;
                    cause_d      = CAUSE_BREAKPOINT;
                    hit_idx_d    = bp_hit_index;
                    stop_pulse_d = 1'b1;
                end else begin
                    o_dp_enable = 1'b1;
                    if (steps_q != '1) begin
                        steps_d = steps_q + NB_STEP'(1);
                    end
                    if (state_q == ST_BURST) begin
                        remain_d = remain_q - NB_STEP'(1);
                        if (remain_q <= NB_STEP'(1)) begin
                            state_d      = ST_IDLE;
                            cause_d      = CAUSE_STEP_DONE;
                            stop_pulse_d = 1'b1;
                        end
                    end
                end
            end
            ST_HALTED: begin
                if (cmd_start) begin
                    cmd_err_d = 1'b1;
                end
                if (cmd_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_cmd_err      = cmd_err_q;
    assign o_stop_pulse   = stop_pulse_q;
    assign o_stop_cause   = cause_q;
    assign o_bp_hit_index = hit_idx_q;
    assign o_steps_done   = steps_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_run_step_controller.sv
// tb/tb_run_step_controller.sv - directed self-checking bench for run_step_controller
module tb_run_step_controller;
    import run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [15:0] step_count;
    logic [1:0]  bp_index;
    logic [31:0] bp_addr;
    logic [31:0] pc_value;
    logic        hlt;
    logic        dp_enable;
    logic        cmd_err;
    logic        stop_pulse;
    logic [2:0]  stop_cause;
    logic [1:0]  bp_hit_index;
    logic [15:0] steps_done;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int sp_cnt = 0;
    logic en_prev = 1'b0;
    logic pc_auto = 1'b0;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_BURST = 3'd2, S_HALTED = 3'd3;

    run_step_controller #(
        .NB_PC(32), .N_BP(4), .NB_BP_IDX(2), .NB_STEP(16)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .i_cmd          (cmd),
        .i_step_count   (step_count),
        .i_bp_index     (bp_index),
        .i_bp_addr      (bp_addr),
        .i_pc_value     (pc_value),
        .i_hlt          (hlt),
        .o_dp_enable    (dp_enable),
        .o_cmd_err      (cmd_err),
        .o_stop_pulse   (stop_pulse),
        .o_stop_cause   (stop_cause),
        .o_bp_hit_index (bp_hit_index),
        .o_steps_done   (steps_done),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample the enable mid-cycle, return 1ns after the edge with the pc model advanced.
    task automatic tick();
        @(negedge clk);
        en_prev = dp_enable;
        if (en_prev) en_cnt++;
        @(posedge clk);
        #1;
        if (stop_pulse) sp_cnt++;
        if (pc_auto && en_prev) pc_value = pc_value + 32'd4;
    endtask

    task automatic send(input logic [2:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic bp(input logic [2:0] c, input logic [1:0] idx, input logic [31:0] addr);
        bp_index = idx;
        bp_addr  = addr;
        send(c);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; step_count = '0;
        bp_index = '0; bp_addr = '0; pc_value = '0; hlt = 1'b0;
        #12;
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_enable", 32'(dp_enable), 0);
        check("rst_cause", 32'(stop_cause), 32'(CAUSE_NONE));
        check("rst_steps", 32'(steps_done), 0);
        check("rst_pulse", 32'(stop_pulse), 0);
        check("rst_err", 32'(cmd_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // single step
        en_cnt = 0; sp_cnt = 0;
        send(CMD_STEP);
        check("step_state_burst", 32'(state), 32'(S_BURST));
        tick();
        check("step_pulse", 32'(stop_pulse), 1);
        check("step_state_idle", 32'(state), 32'(S_IDLE));
        tick(); tick();
        check("step_enables", 32'(en_cnt), 1);
        check("step_cause", 32'(stop_cause), 32'(CAUSE_STEP_DONE));
        check("step_steps", 32'(steps_done), 1);

        // burst of 5, then zero-length burst
        en_cnt = 0; sp_cnt = 0; step_count = 16'd5;
        send(CMD_BURST);
        for (int k = 0; k < 20 && state != S_IDLE; k++) tick();
        tick();
        check("b5_state", 32'(state), 32'(S_IDLE));
        check("b5_enables", 32'(en_cnt), 5);
        check("b5_steps", 32'(steps_done), 5);
        check("b5_pulses", 32'(sp_cnt), 1);
        en_cnt = 0; sp_cnt = 0; step_count = 16'd0;
        send(CMD_BURST);
        check("b0_pulse", 32'(stop_pulse), 1);
        tick(); tick();
        check("b0_enables", 32'(en_cnt), 0);
        check("b0_cause", 32'(stop_cause), 32'(CAUSE_STEP_DONE));
        check("b0_state", 32'(state), 32'(S_IDLE));

        // undefined command code
        send(3'd7);
        check("undef_err", 32'(cmd_err), 1);
        tick();
        check("undef_err_clear", 32'(cmd_err), 0);

        // breakpoint stop at 0x10, then leave it
        bp(CMD_BP_SET, 2'd2, 32'h10);
        pc_value = 32'h0; pc_auto = 1'b1; en_cnt = 0;
        send(CMD_RUN);
        for (int k = 0; k < 50 && state == S_RUN; k++) tick();
        check("bp_state", 32'(state), 32'(S_IDLE));
        check("bp_cause", 32'(stop_cause), 32'(CAUSE_BREAKPOINT));
        check("bp_index", 32'(bp_hit_index), 2);
        check("bp_steps", 32'(steps_done), 4);
        check("bp_pc", pc_value, 32'h10);
        send(CMD_RUN);
        tick(); tick();
        check("rerun_state", 32'(state), 32'(S_RUN));
        check("rerun_pc", pc_value, 32'h18);
        check("rerun_cause", 32'(stop_cause), 32'(CAUSE_NONE));
        send(CMD_STOP);
        check("rerun_stop_cause", 32'(stop_cause), 32'(CAUSE_USER_STOP));
        pc_auto = 1'b0;
        bp(CMD_BP_CLR, 2'd2, 32'h0);

        // halt wins over a breakpoint in the same cycle
        bp(CMD_BP_SET, 2'd1, 32'h20);
        pc_value = 32'h20;
        send(CMD_RUN);
        tick();
        check("hlt_first_en", 32'(en_prev), 1);
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        check("hlt_en_low", 32'(en_prev), 0);
        check("hlt_state", 32'(state), 32'(S_HALTED));
        check("hlt_cause", 32'(stop_cause), 32'(CAUSE_HALT));
        check("hlt_pulse", 32'(stop_pulse), 1);
        send(CMD_RUN);
        check("hlt_run_err", 32'(cmd_err), 1);
        check("hlt_still", 32'(state), 32'(S_HALTED));
        send(CMD_STOP);
        check("hlt_stop_state", 32'(state), 32'(S_IDLE));
        check("hlt_cause_kept", 32'(stop_cause), 32'(CAUSE_HALT));
        bp(CMD_BP_CLR, 2'd1, 32'h0);

        // long burst interrupted: RUN rejected, then user stop
        pc_value = 32'h100; en_cnt = 0; step_count = 16'd100;
        send(CMD_BURST);
        for (int k = 0; k < 9; k++) tick();
        send(CMD_RUN);
        check("b100_err", 32'(cmd_err), 1);
        check("b100_state", 32'(state), 32'(S_BURST));
        for (int k = 0; k < 10; k++) tick();
        send(CMD_STOP);
        check("b100_stop_state", 32'(state), 32'(S_IDLE));
        check("b100_cause", 32'(stop_cause), 32'(CAUSE_USER_STOP));
        check("b100_steps", 32'(steps_done), 20);
        check("b100_enables", 32'(en_cnt), 20);

        // two slots on the same address: lowest index reported
        bp(CMD_BP_SET, 2'd3, 32'h8);
        bp(CMD_BP_SET, 2'd0, 32'h8);
        pc_value = 32'h0; pc_auto = 1'b1;
        send(CMD_RUN);
        for (int k = 0; k < 50 && state == S_RUN; k++) tick();
        check("dual_cause", 32'(stop_cause), 32'(CAUSE_BREAKPOINT));
        check("dual_index", 32'(bp_hit_index), 0);
        check("dual_pc", pc_value, 32'h8);

        // asynchronous reset mid-run
        send(CMD_RUN);
        tick(); tick();
        check("prerst_state", 32'(state), 32'(S_RUN));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'(S_IDLE));
        check("arst_enable", 32'(dp_enable), 0);
        check("arst_steps", 32'(steps_done), 0);
        check("arst_cause", 32'(stop_cause), 32'(CAUSE_NONE));
        check("arst_index", 32'(bp_hit_index), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pc_auto = 1'b0; pc_value = 32'h8;
        send(CMD_RUN);
        tick(); tick(); tick();
        check("bp_lost_state", 32'(state), 32'(S_RUN));
        send(CMD_STOP);
        check("bp_lost_cause", 32'(stop_cause), 32'(CAUSE_USER_STOP));
        check("bp_lost_steps", 32'(steps_done), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
